// File: rtl/rx_core_sequencer.sv
// rx_core_sequencer: owns the receive core's reset/enable, blocking it around TX and on demod stalls.
module rx_core_sequencer #(
    parameter int WDOG_WIDTH    = 20,
    parameter int RST_PULSE_LEN = 8,
    parameter int HOLD_WIDTH    = 16,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                  s00_axi_aclk,
    input  logic                  s00_axi_aresetn,
    input  logic                  sw_rst_req,
    input  logic                  tx_active,
    input  logic [HOLD_WIDTH-1:0] holdoff_cycles,
    input  logic                  wdog_en,
    input  logic [WDOG_WIDTH-1:0] wdog_limit,
    input  logic                  demod_is_ongoing,
    input  logic                  pkt_header_valid_strobe,
    input  logic                  byte_out_strobe,
    input  logic                  fcs_out_strobe,
    output logic                  core_rst,
    output logic                  core_enable,
    output logic [CNT_WIDTH-1:0]  wdog_fire_count,
    output logic [2:0]            seq_state
);
    localparam int PW = $clog2(RST_PULSE_LEN + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RX       = 3'd1,
        RESET    = 3'd2,
        TX_BLOCK = 3'd3,
        HOLDOFF  = 3'd4
    } state_t;

    state_t                state, state_nx;
    logic [PW-1:0]         pulse_cnt, pulse_nx;
    logic [WDOG_WIDTH-1:0] wdog_cnt, wdog_nx;
    logic [HOLD_WIDTH-1:0] hold_cnt, hold_nx;
    logic [WDOG_WIDTH:0]   wdog_inc;
    logic                  fire, progress, wdog_hit, rx_done;

    assign progress  = pkt_header_valid_strobe | byte_out_strobe;
    assign rx_done   = fcs_out_strobe | ~demod_is_ongoing;
    assign wdog_inc  = {1'b0, wdog_cnt} + {{WDOG_WIDTH{1'b0}}, 1'b1};
    // limit reached means this cycle would be the limit-th stalled cycle in RX
    assign wdog_hit  = wdog_en && (wdog_limit != '0) && (wdog_inc == {1'b0, wdog_limit});
    assign seq_state = state;

    always_comb begin
        state_nx = state;
        pulse_nx = pulse_cnt;
        wdog_nx  = wdog_cnt;
        hold_nx  = hold_cnt;
        fire     = 1'b0;
        if (sw_rst_req) begin
            state_nx = RESET;
            pulse_nx = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tx_active) state_nx = TX_BLOCK;
                    else if (demod_is_ongoing) begin
                        state_nx = RX;
                        wdog_nx  = '0;
                    end
                end
                RX: begin
                    if (tx_active) begin
                        state_nx = RESET;
                        pulse_nx = '0;
                    end else if (progress) begin
                        wdog_nx  = '0;
                        state_nx = rx_done ? IDLE : RX;
                    end else if (wdog_hit) begin
                        state_nx = RESET;
                        pulse_nx = '0;
                        fire     = 1'b1;
                    end else begin
                        wdog_nx  = wdog_inc[WDOG_WIDTH-1:0];
                        state_nx = rx_done ? IDLE : RX;
                    end
                end
                RESET: begin
                    if (pulse_cnt == PW'(RST_PULSE_LEN - 1)) state_nx = tx_active ? TX_BLOCK : IDLE;
                    else pulse_nx = pulse_cnt + 1'b1;
                end
                TX_BLOCK: begin
                    if (!tx_active) begin
                        state_nx = (holdoff_cycles == '0) ? IDLE : HOLDOFF;
                        hold_nx  = holdoff_cycles;
                    end
                end
                HOLDOFF: begin
                    if (tx_active) state_nx = TX_BLOCK;
                    else if (hold_cnt == HOLD_WIDTH'(1)) state_nx = IDLE;
                    else hold_nx = hold_cnt - 1'b1;
                end
                default: begin
                    state_nx = RESET;
                    pulse_nx = '0;
                end
            endcase
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state           <= RESET;
            pulse_cnt       <= '0;
            wdog_cnt        <= '0;
            hold_cnt        <= '0;
            core_rst        <= 1'b1;
            core_enable     <= 1'b0;
            wdog_fire_count <= '0;
        end else begin
            state       <= state_nx;
            pulse_cnt   <= pulse_nx;
            wdog_cnt    <= wdog_nx;
            hold_cnt    <= hold_nx;
            core_rst    <= (state_nx == RESET);
            core_enable <= (state_nx == IDLE) || (state_nx == RX);
            if (fire && !(&wdog_fire_count)) wdog_fire_count <= wdog_fire_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_rx_core_sequencer.sv
// tb_rx_core_sequencer: directed scenario bench for rx_core_sequencer.
module tb_rx_core_sequencer;
    logic        clk = 1'b0;
    logic        rst_n, rst_sat_n;
    logic        sw_rst_req, tx_active, wdog_en, demod, hdr_stb, byte_stb, fcs_stb;
    logic [15:0] holdoff_cycles;
    logic [19:0] wdog_limit;
    logic        core_rst, core_enable, sat_rst, sat_en;
    logic [15:0] fire_cnt;
    logic [3:0]  sat_cnt;
    logic [2:0]  seq_state, sat_state;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    rx_core_sequencer u_dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .sw_rst_req(sw_rst_req),
        .tx_active(tx_active), .holdoff_cycles(holdoff_cycles), .wdog_en(wdog_en),
        .wdog_limit(wdog_limit), .demod_is_ongoing(demod), .pkt_header_valid_strobe(hdr_stb),
        .byte_out_strobe(byte_stb), .fcs_out_strobe(fcs_stb), .core_rst(core_rst),
        .core_enable(core_enable), .wdog_fire_count(fire_cnt), .seq_state(seq_state)
    );

    // short pulse and narrow counter so saturation is reachable in a few hundred cycles
    rx_core_sequencer #(.RST_PULSE_LEN(2), .CNT_WIDTH(4)) u_sat (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_sat_n), .sw_rst_req(sw_rst_req),
        .tx_active(tx_active), .holdoff_cycles(holdoff_cycles), .wdog_en(wdog_en),
        .wdog_limit(wdog_limit), .demod_is_ongoing(demod), .pkt_header_valid_strobe(hdr_stb),
        .byte_out_strobe(byte_stb), .fcs_out_strobe(fcs_stb), .core_rst(sat_rst),
        .core_enable(sat_en), .wdog_fire_count(sat_cnt), .seq_state(sat_state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic count_while_rst(output int n);
        n = 0;
        while (core_rst && n < 50) begin
            n++;
            step();
        end
    endtask

    task automatic count_while_disabled(output int n);
        n = 0;
        while (!core_enable && n < 100) begin
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0; rst_sat_n = 1'b0; sw_rst_req = 1'b0; tx_active = 1'b0; wdog_en = 1'b0;
        demod = 1'b0; hdr_stb = 1'b0; byte_stb = 1'b0; fcs_stb = 1'b0;
        holdoff_cycles = 16'd0; wdog_limit = 20'd0;
        repeat (3) step();
        checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst got %0b exp 1", core_rst); end
        checks++; if (core_enable !== 1'b0) begin errors++; $display("FAIL reset_core_enable got %0b exp 0", core_enable); end
        checks++; if (seq_state !== 3'd2) begin errors++; $display("FAIL reset_state got %0d exp 2", seq_state); end
        checks++; if (fire_cnt !== 16'd0) begin errors++; $display("FAIL reset_fire_cnt got %0d exp 0", fire_cnt); end
        rst_n = 1'b1;
        count_while_rst(n);
        checks++; if (n != 8) begin errors++; $display("FAIL release_pulse_len got %0d exp 8", n); end
        checks++; if (seq_state !== 3'd0) begin errors++; $display("FAIL release_state got %0d exp 0", seq_state); end
        checks++; if (core_enable !== 1'b1) begin errors++; $display("FAIL release_enable got %0b exp 1", core_enable); end
    endtask

    task automatic test_watchdog();
        int n;
        wdog_en = 1'b1; wdog_limit = 20'd100; demod = 1'b1;
        step();
        checks++; if (seq_state !== 3'd1) begin errors++; $display("FAIL wd_rx_entry got %0d exp 1", seq_state); end
        n = 0;
        while (seq_state !== 3'd2 && n < 300) begin
            step();
            n++;
        end
        checks++; if (n != 100) begin errors++; $display("FAIL wd_fire_latency got %0d exp 100", n); end
        count_while_rst(n);
        demod = 1'b0;
        checks++; if (n != 8) begin errors++; $display("FAIL wd_pulse_len got %0d exp 8", n); end
        checks++; if (fire_cnt !== 16'd1) begin errors++; $display("FAIL wd_fire_cnt got %0d exp 1", fire_cnt); end
        checks++; if (seq_state !== 3'd0) begin errors++; $display("FAIL wd_back_idle got %0d exp 0", seq_state); end
    endtask

    task automatic test_progress();
        int bad;
        demod = 1'b1;
        step();
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            byte_stb = (i % 50 == 49);
            step();
            byte_stb = 1'b0;
            if (seq_state !== 3'd1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL prog_left_rx got %0d cycles exp 0", bad); end
        checks++; if (fire_cnt !== 16'd1) begin errors++; $display("FAIL prog_fire_cnt got %0d exp 1", fire_cnt); end
        fcs_stb = 1'b1;
        step();
        fcs_stb = 1'b0; demod = 1'b0;
        checks++; if (seq_state !== 3'd0) begin errors++; $display("FAIL prog_fcs_idle got %0d exp 0", seq_state); end
        // progress on the exact limit cycle must win over the fire
        demod = 1'b1;
        step();
        repeat (99) step();
        checks++; if (seq_state !== 3'd1) begin errors++; $display("FAIL prog_pre_limit got %0d exp 1", seq_state); end
        hdr_stb = 1'b1;
        step();
        hdr_stb = 1'b0;
        checks++; if (seq_state !== 3'd1 || fire_cnt !== 16'd1) begin
            errors++; $display("FAIL prog_tie state=%0d cnt=%0d exp 1/1", seq_state, fire_cnt);
        end
        wdog_limit = 20'd0;
        bad = 0;
        repeat (300) begin
            step();
            if (seq_state !== 3'd1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL prog_limit0 left rx %0d cycles exp 0", bad); end
        demod = 1'b0;
        step();
        checks++; if (seq_state !== 3'd0) begin errors++; $display("FAIL prog_demod_low got %0d exp 0", seq_state); end
    endtask

    task automatic test_tx_holdoff();
        int n, bad;
        holdoff_cycles = 16'd30; demod = 1'b1;
        step();
        tx_active = 1'b1;
        step();
        demod = 1'b0;
        checks++; if (seq_state !== 3'd2) begin errors++; $display("FAIL tx_abort_state got %0d exp 2", seq_state); end
        count_while_rst(n);
        checks++; if (n != 8) begin errors++; $display("FAIL tx_abort_pulse got %0d exp 8", n); end
        bad = 0;
        repeat (11) begin
            if (seq_state !== 3'd3 || core_enable !== 1'b0) bad++;
            step();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL tx_block_hold bad=%0d exp 0", bad); end
        tx_active = 1'b0;
        step();
        checks++; if (seq_state !== 3'd4) begin errors++; $display("FAIL holdoff_entry got %0d exp 4", seq_state); end
        count_while_disabled(n);
        checks++; if (n != 30) begin errors++; $display("FAIL holdoff_len got %0d exp 30", n); end
        checks++; if (seq_state !== 3'd0) begin errors++; $display("FAIL holdoff_idle got %0d exp 0", seq_state); end
    endtask

    task automatic test_tx_restart();
        int n;
        holdoff_cycles = 16'd0; tx_active = 1'b1;
        step();
        checks++; if (seq_state !== 3'd3) begin errors++; $display("FAIL tx_idle_block got %0d exp 3", seq_state); end
        tx_active = 1'b0;
        step();
        checks++; if (seq_state !== 3'd0 || core_enable !== 1'b1) begin
            errors++; $display("FAIL zero_holdoff state=%0d en=%0b exp 0/1", seq_state, core_enable);
        end
        holdoff_cycles = 16'd30; tx_active = 1'b1;
        step();
        tx_active = 1'b0;
        step();
        repeat (9) step();
        checks++; if (seq_state !== 3'd4) begin errors++; $display("FAIL holdoff_mid got %0d exp 4", seq_state); end
        tx_active = 1'b1;
        step();
        checks++; if (seq_state !== 3'd3) begin errors++; $display("FAIL holdoff_retx got %0d exp 3", seq_state); end
        tx_active = 1'b0;
        step();
        count_while_disabled(n);
        checks++; if (n != 30) begin errors++; $display("FAIL holdoff_restart got %0d exp 30", n); end
    endtask

    task automatic test_sw_reset();
        int n, m;
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        n = core_rst ? 1 : 0;
        repeat (4) begin
            step();
            if (core_rst) n++;
        end
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        count_while_rst(m);
        checks++; if (n + m != 13) begin errors++; $display("FAIL sw_restart_len got %0d exp 13", n + m); end
        checks++; if (seq_state !== 3'd0) begin errors++; $display("FAIL sw_back_idle got %0d exp 0", seq_state); end
    endtask

    task automatic test_saturation();
        rst_sat_n = 1'b1; demod = 1'b1; wdog_en = 1'b1; wdog_limit = 20'd1;
        repeat (20) step();
        checks++; if (sat_cnt !== 4'd5) begin errors++; $display("FAIL sat_count5 got %0d exp 5", sat_cnt); end
        repeat (44) step();
        checks++; if (sat_cnt !== 4'hF) begin errors++; $display("FAIL sat_hold64 got %0d exp 15", sat_cnt); end
        repeat (100) step();
        checks++; if (sat_cnt !== 4'hF) begin errors++; $display("FAIL sat_hold164 got %0d exp 15", sat_cnt); end
        demod = 1'b0;
    endtask

    initial begin
        test_reset();
        test_watchdog();
        test_progress();
        test_tx_holdoff();
        test_tx_restart();
        test_sw_reset();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
